// File: rtl/mlcd_line_writer_if.sv
// Control, line-buffer and panel-pin signals of the memory-LCD line writer.
// The master side is the frame controller plus line buffer; the slave side is the writer.
interface mlcd_line_writer_if #(
  parameter int unsigned AW = 4
);
  logic          i_start;
  logic [7:0]    i_line_addr;
  logic          o_pix_rd;
  logic [AW-1:0] o_pix_addr;
  logic [7:0]    i_pix_data;
  logic          o_busy;
  logic          o_done;
  logic          o_scs;
  logic          o_sclk;
  logic          o_si;

  modport master (
    output i_start, i_line_addr, i_pix_data,
    input  o_pix_rd, o_pix_addr, o_busy, o_done, o_scs, o_sclk, o_si
  );

  modport slave (
    input  i_start, i_line_addr, i_pix_data,
    output o_pix_rd, o_pix_addr, o_busy, o_done, o_scs, o_sclk, o_si
  );
endinterface

// File: rtl/mlcd_line_writer.sv
// Serialises one line write (command, address, pixel bytes, trailer) onto a memory-LCD 3-wire bus.
// Define MLCD_VCOM_EN to toggle M1 (VCOM) internally every VCOM_EVERY lines; otherwise M1 is 0.
module mlcd_line_writer #(
  parameter int unsigned DIV        = 4,
  parameter int unsigned LINE_BITS  = 96,
  parameter int unsigned CS_SETUP   = 2,
  parameter int unsigned CS_HOLD    = 2,
  parameter int unsigned VCOM_EVERY = 96
) (
  input  logic              i_clk,
  input  logic              i_reset,
  mlcd_line_writer_if.slave bus
);

  localparam int unsigned NBYTES = LINE_BITS / 8;
  localparam int unsigned AW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned CW     = $clog2(DIV);
  localparam int unsigned MAXA   = (LINE_BITS > 16) ? LINE_BITS : 16;
  localparam int unsigned MAXB   = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int unsigned MAXC   = (MAXA > MAXB) ? MAXA : MAXB;
  localparam int unsigned BW     = $clog2(MAXC);

  if (DIV < 2 || LINE_BITS == 0 || (LINE_BITS % 8) != 0 || VCOM_EVERY == 0) begin : g_bad_cfg
    $error("mlcd_line_writer: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_CMD, S_ADDR, S_DATA, S_TRAIL, S_HOLD
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            half_q, half_d;
  logic [BW-1:0]   idx_q, idx_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      hold_q, hold_d;
  logic [AW-1:0]   paddr_q, paddr_d;
  logic            rd_q, rd_d;
  logic            rd_dly_q, rd_dly_d;
  logic            scs_q, scs_d;
  logic            sclk_q, sclk_d;
  logic            si_q, si_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            tick;
  logic            load;
  logic            vcom;
  logic [BW-1:0]   last_idx;
  logic [7:0]      cmd_byte;

  assign tick     = (cnt_q == CW'(DIV - 1));
  assign cmd_byte = {5'b0, 1'b0, vcom, 1'b1};

  function automatic logic field_bit(input state_e s, input logic [2:0] b,
                                     input logic [7:0] cmd, input logic [7:0] adr,
                                     input logic [7:0] dat);
    case (s)
      S_CMD:   return cmd[b];
      S_ADDR:  return adr[b];
      S_DATA:  return dat[b];
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    case (state_q)
      S_DATA:  last_idx = BW'(LINE_BITS - 1);
      S_TRAIL: last_idx = BW'(15);
      default: last_idx = BW'(7);
    endcase
  end

  // Next state: a bit is two ticks, low half presents the bit, high half lets the panel sample it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    half_d   = half_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    hold_d   = hold_q;
    paddr_d  = paddr_q;
    rd_d     = 1'b0;
    rd_dly_d = rd_q;
    scs_d    = scs_q;
    sclk_d   = sclk_q;
    si_d     = si_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    load     = 1'b0;

    if (state_q != S_IDLE) cnt_d = tick ? '0 : cnt_q + CW'(1);
    if (rd_q)              paddr_d = paddr_q + AW'(1);
    if (rd_dly_q)          hold_d = bus.i_pix_data;

    unique case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        paddr_d = '0;
        if (bus.i_start) begin
          state_d = S_SETUP;
          addr_d  = bus.i_line_addr;
          idx_d   = '0;
          half_d  = 1'b0;
          busy_d  = 1'b1;
          scs_d   = 1'b1;
          sclk_d  = 1'b0;
          si_d    = 1'b0;
        end
      end
      S_SETUP: if (tick) begin
        if (idx_q == BW'(CS_SETUP - 1)) begin
          state_d = S_CMD;
          idx_d   = '0;
          half_d  = 1'b0;
          load    = 1'b1;
        end else begin
          idx_d = idx_q + BW'(1);
        end
      end
      S_HOLD: if (tick) begin
        if (idx_q == BW'(CS_HOLD - 1)) begin
          state_d = S_IDLE;
          idx_d   = '0;
          paddr_d = '0;
          scs_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + BW'(1);
        end
      end
      default: if (tick) begin
        if (!half_q) begin
          half_d = 1'b1;
          sclk_d = 1'b1;
        end else begin
          half_d = 1'b0;
          sclk_d = 1'b0;
          load   = 1'b1;
          idx_d  = idx_q + BW'(1);
          if (idx_q == last_idx) begin
            idx_d = '0;
            case (state_q)
              S_CMD:   state_d = S_ADDR;
              S_ADDR:  state_d = S_DATA;
              S_DATA:  state_d = S_TRAIL;
              default: state_d = S_HOLD;
            endcase
          end
        end
      end
    endcase

    // New bit on SI; bit 7 of the address and of each non-final byte prefetches the next byte.
    if (load) begin
      si_d = field_bit(state_d, idx_d[2:0], cmd_byte, addr_q, hold_q);
      rd_d = (state_d == S_ADDR && idx_d == BW'(7)) ||
             (state_d == S_DATA && idx_d[2:0] == 3'd7 && idx_d < BW'(LINE_BITS - 8));
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      half_q   <= 1'b0;
      idx_q    <= '0;
      addr_q   <= '0;
      hold_q   <= '0;
      paddr_q  <= '0;
      rd_q     <= 1'b0;
      rd_dly_q <= 1'b0;
      scs_q    <= 1'b0;
      sclk_q   <= 1'b0;
      si_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      half_q   <= half_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      hold_q   <= hold_d;
      paddr_q  <= paddr_d;
      rd_q     <= rd_d;
      rd_dly_q <= rd_dly_d;
      scs_q    <= scs_d;
      sclk_q   <= sclk_d;
      si_q     <= si_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef MLCD_VCOM_EN
  localparam int unsigned LW = $clog2(VCOM_EVERY + 1);

  logic          vcom_q, vcom_d;
  logic [LW-1:0] lines_q, lines_d;

  // Flag flips in the o_done cycle of every VCOM_EVERY-th line.
  always_comb begin
    vcom_d  = vcom_q;
    lines_d = lines_q;
    if (done_d) begin
      if (lines_q == LW'(VCOM_EVERY - 1)) begin
        lines_d = '0;
        vcom_d  = ~vcom_q;
      end else begin
        lines_d = lines_q + LW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      vcom_q  <= 1'b0;
      lines_q <= '0;
    end else begin
      vcom_q  <= vcom_d;
      lines_q <= lines_d;
    end
  end

  assign vcom = vcom_q;
`else
  assign vcom = 1'b0;
`endif

  assign bus.o_pix_rd   = rd_q;
  assign bus.o_pix_addr = paddr_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_done     = done_q;
  assign bus.o_scs      = scs_q;
  assign bus.o_sclk     = sclk_q;
  assign bus.o_si       = si_q;

endmodule

// File: tb/tb_mlcd_line_writer.sv
// Bench for mlcd_line_writer: decodes the serial stream and scores it against per-line expectations.
// Build with MLCD_VCOM_EN to exercise the internal VCOM toggling (VCOM_EVERY = 2).
module tb_mlcd_line_writer;

  localparam int unsigned DIV        = 4;
  localparam int unsigned LINE_BITS  = 96;
  localparam int unsigned NBYTES     = LINE_BITS / 8;
  localparam int unsigned CS_SETUP   = 2;
  localparam int unsigned CS_HOLD    = 2;
  localparam int unsigned VCOM_EVERY = 2;
  localparam int          LAT        = 1041;
`ifdef MLCD_VCOM_EN
  localparam bit M1_ON = 1'b1;
`else
  localparam bit M1_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  mlcd_line_writer_if #(.AW(4)) bus ();

  mlcd_line_writer #(
    .DIV(DIV), .LINE_BITS(LINE_BITS), .CS_SETUP(CS_SETUP),
    .CS_HOLD(CS_HOLD), .VCOM_EVERY(VCOM_EVERY)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [NBYTES];
  logic [7:0] exp_q [$];
  int         done_cnt = 0;
  int         lines_done = 0;

  task automatic check(input string name, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, want);
    end
  endtask

  task automatic check_ge(input string name, input longint got, input longint min);
    total++;
    if (got < min) begin
      bad++;
      $display("FAIL %s: got %0d, required >= %0d", name, got, min);
    end
  endtask

  // Synchronous line buffer: data valid for exactly the one cycle after a request.
  always @(posedge clk)
    bus.i_pix_data <= bus.o_pix_rd ? mem[bus.o_pix_addr] : 8'h3C;

  // Panel-side monitor, sampled on the falling edge.
  int         mcyc = 0;
  int         scs_rise_c = 0;
  int         last_fall_c = 0;
  int         nbit = 0;
  int         rd_idx = 0;
  int         si_viol = 0;
  bit         first_rise = 1'b1;
  logic       prev_sclk = 1'b0;
  logic       prev_si = 1'b0;
  logic       prev_scs = 1'b0;
  logic [7:0] sh = 8'h00;

  always @(negedge clk) begin
    mcyc++;
    if (rst) begin
      exp_q.delete();
      nbit = 0;
      rd_idx = 0;
      first_rise = 1'b1;
      prev_sclk = 1'b0;
      prev_si = 1'b0;
      prev_scs = 1'b0;
    end else begin
      if (bus.o_done) done_cnt++;
      if (bus.o_scs && !prev_scs) begin
        scs_rise_c = mcyc;
        first_rise = 1'b1;
        rd_idx = 0;
        nbit = 0;
      end
      if (bus.o_pix_rd) begin
        check("pix_addr", bus.o_pix_addr, rd_idx);
        rd_idx++;
      end
      if (bus.o_si != prev_si && bus.o_sclk) si_viol++;
      if (bus.o_sclk && !prev_sclk) begin
        if (first_rise) begin
          check_ge("scs_setup_cycles", mcyc - scs_rise_c, CS_SETUP * DIV);
          first_rise = 1'b0;
        end
        sh = {bus.o_si, sh[7:1]};
        nbit++;
        if (nbit == 8) begin
          nbit = 0;
          if (exp_q.size() == 0) check("unexpected_byte", sh, 256);
          else                   check("si_byte", sh, exp_q.pop_front());
        end
      end
      if (!bus.o_sclk && prev_sclk) last_fall_c = mcyc;
      if (!bus.o_scs && prev_scs) check_ge("scs_hold_cycles", mcyc - last_fall_c, CS_HOLD * DIV);
      prev_sclk = bus.o_sclk;
      prev_si   = bus.o_si;
      prev_scs  = bus.o_scs;
    end
  end

  function automatic bit m1_model(input int n);
    return M1_ON && (((n / VCOM_EVERY) % 2) == 1);
  endfunction

  task automatic fill(input logic [7:0] seed, input logic [7:0] step);
    for (int i = 0; i < NBYTES; i++) mem[i] = 8'(seed + 8'(i) * step);
  endtask

  task automatic push_line(input logic [7:0] a, input bit m1);
    exp_q.push_back({6'b0, m1, 1'b1});
    exp_q.push_back(a);
    for (int i = 0; i < NBYTES; i++) exp_q.push_back(mem[i]);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
  endtask

  // One line: optional stray i_start at cycle glitch_at while busy.
  task automatic run_line(input logic [7:0] a, input bit m1, input int lat, input int glitch_at);
    int n;
    int d0;
    push_line(a, m1);
    d0 = done_cnt;
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_line_addr = a;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_line_addr = 8'hEE;
    n = 1;
    check("busy_after_start", bus.o_busy, 1);
    check("scs_after_start", bus.o_scs, 1);
    while (!bus.o_done && n < 3000) begin
      if (n == glitch_at) begin
        bus.i_start = 1'b1;
        bus.i_line_addr = 8'h77;
      end else begin
        bus.i_start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bus.i_start = 1'b0;
    check("done_latency", n, lat);
    check("busy_low_at_done", bus.o_busy, 0);
    @(negedge clk);
    check("done_one_cycle", bus.o_done, 0);
    check("scs_low_after", bus.o_scs, 0);
    check("pix_addr_idle", bus.o_pix_addr, 0);
    check("bytes_outstanding", exp_q.size(), 0);
    check("pix_rd_count", rd_idx, NBYTES);
    check("si_change_while_sclk_high", si_viol, 0);
    repeat (4) @(negedge clk);
    check("done_count", done_cnt - d0, 1);
    check("busy_stays_low", bus.o_busy, 0);
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] seed;
    logic [7:0] step;
    bit         exp_m1;
    int         exp_lat;
  } vec_t;

  initial begin
    vec_t vt [6];
    int   d0;
    int   w;

    vt[0] = '{8'h05, 8'hA5, 8'h01, 1'b0,  LAT};
    vt[1] = '{8'h01, 8'h00, 8'h00, 1'b0,  LAT};
    vt[2] = '{8'hF0, 8'hFF, 8'h00, M1_ON, LAT};
    vt[3] = '{8'hFF, 8'h01, 8'h02, M1_ON, LAT};
    vt[4] = '{8'h80, 8'h3C, 8'h11, 1'b0,  LAT};
    vt[5] = '{8'hAA, 8'h96, 8'hFF, 1'b0,  LAT};

    bus.i_start = 1'b0;
    bus.i_line_addr = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.o_busy, 0);
    check("rst_done", bus.o_done, 0);
    check("rst_scs", bus.o_scs, 0);
    check("rst_sclk", bus.o_sclk, 0);
    check("rst_si", bus.o_si, 0);
    check("rst_pix_rd", bus.o_pix_rd, 0);
    check("rst_pix_addr", bus.o_pix_addr, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      fill(vt[k].seed, vt[k].step);
      run_line(vt[k].addr, vt[k].exp_m1, vt[k].exp_lat, -1);
      lines_done++;
    end

    // Stray start while busy must not disturb the line in flight.
    fill(8'h5A, 8'h07);
    run_line(8'h21, m1_model(lines_done), LAT, 300);
    lines_done++;

    // Reset in the middle of DATA, while SCLK is high and SI carries a 1.
    fill(8'hFF, 8'h00);
    push_line(8'h42, m1_model(lines_done));
    d0 = done_cnt;
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_line_addr = 8'h42;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (500) @(negedge clk);
    w = 0;
    while (!bus.o_sclk && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("sclk_high_before_reset", bus.o_sclk, 1);
    rst = 1'b1;
    #1;
    check("async_rst_scs", bus.o_scs, 0);
    check("async_rst_sclk", bus.o_sclk, 0);
    check("async_rst_si", bus.o_si, 0);
    check("async_rst_busy", bus.o_busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    lines_done = 0;
    repeat (5) @(negedge clk);
    check("no_done_after_abort", done_cnt - d0, 0);
    check("idle_after_abort", bus.o_busy, 0);
    check("pix_addr_after_abort", bus.o_pix_addr, 0);

    fill(8'hC3, 8'h05);
    run_line(8'h99, m1_model(lines_done), LAT, -1);
    lines_done++;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
